// File: rtl/sd_host_platform_generic.sv
`default_nettype none
// ============================================================================
// Module   : sd_host_platform_generic
// Brief    : SD host PHY platform layer - programmable gated SD clock,
//            rise/fall strobes, registered CMD/DATA launch and capture.
// Revision : 1.0
// ============================================================================
module sd_host_platform_generic #(
    parameter int DATA_WIDTH  = 4,
    parameter int LOCK_CYCLES = 16,
    parameter int DIV_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_locked,
    input  logic                  i_clk_en,
    input  logic [DIV_WIDTH-1:0]  i_clk_div,
    output logic                  o_clk_stopped,
    output logic                  o_phy_out_clk,
    output logic                  o_sd_clk_rise,
    output logic                  o_sd_clk_fall,
    input  logic                  i_sd_cmd_dir,
    input  logic                  i_sd_cmd_out,
    output logic                  o_sd_cmd_in,
    input  logic                  i_sd_data_dir,
    input  logic [DATA_WIDTH-1:0] i_sd_data_out,
    output logic [DATA_WIDTH-1:0] o_sd_data_in,
    inout  wire                   io_phy_sd_cmd,
    inout  wire  [DATA_WIDTH-1:0] io_phy_sd_data
);

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

    localparam logic [1:0] STOPPED = 2'd0;
    localparam logic [1:0] HIGH    = 2'd1;
    localparam logic [1:0] LOW     = 2'd2;

    // ------------------------------------------------------------------
    // Lock counter
    // ------------------------------------------------------------------
    logic [15:0] lock_count;
    logic        locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_count <= 16'd0;
            locked     <= 1'b0;
        end else if (!locked) begin
            lock_count <= lock_count + 16'd1;
            locked     <= (lock_count == LOCK_LAST);
        end
    end

    assign o_locked = locked;

    // ------------------------------------------------------------------
    // Divider state machine
    // ------------------------------------------------------------------
    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] count_next;
    logic                 phase_done;
    logic                 phy_clk;
    logic                 phy_clk_next;
    logic                 rise;
    logic                 rise_next;
    logic                 fall;
    logic                 fall_next;
    logic                 stopped;
    logic                 stopped_next;

    // >= rather than == so a divisor lowered mid-phase ends it without wrapping
    assign phase_done = (count >= i_clk_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= STOPPED;
            count   <= '0;
            phy_clk <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            stopped <= 1'b1;
        end else begin
            state   <= state_next;
            count   <= count_next;
            phy_clk <= phy_clk_next;
            rise    <= rise_next;
            fall    <= fall_next;
            stopped <= stopped_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            STOPPED: begin
                count_next = '0;
                if (locked && i_clk_en) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    state_next = LOW;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            LOW: begin
                if (phase_done) begin
                    state_next = i_clk_en ? HIGH : STOPPED;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = STOPPED;
                count_next = '0;
            end
        endcase
    end

    // Strobes mark the first cycle of a new phase, so they derive from the transition
    always_comb begin
        phy_clk_next = (state_next == HIGH);
        rise_next    = (state_next == HIGH) && (state != HIGH);
        fall_next    = (state_next == LOW) && (state != LOW);
        stopped_next = (state_next == STOPPED);
    end

    assign o_phy_out_clk = phy_clk;
    assign o_sd_clk_rise = rise;
    assign o_sd_clk_fall = fall;
    assign o_clk_stopped = stopped;

    // ------------------------------------------------------------------
    // Launch: pin drive registers
    // ------------------------------------------------------------------
    logic                  launch;
    logic                  cmd_drive_en;
    logic                  cmd_drive_val;
    logic                  data_drive_en;
    logic [DATA_WIDTH-1:0] data_drive_val;

    // While parked the stack may pre-load the pins ahead of the first edge
    assign launch = fall || stopped;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_drive_en   <= 1'b0;
            cmd_drive_val  <= 1'b0;
            data_drive_en  <= 1'b0;
            data_drive_val <= '0;
        end else if (launch) begin
            cmd_drive_en   <= i_sd_cmd_dir;
            cmd_drive_val  <= i_sd_cmd_out;
            data_drive_en  <= i_sd_data_dir;
            data_drive_val <= i_sd_data_out;
        end
    end

    assign io_phy_sd_cmd = cmd_drive_en ? cmd_drive_val : 1'bz;

    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_data_pin
        assign io_phy_sd_data[b] = data_drive_en ? data_drive_val[b] : 1'bz;
    end

    // ------------------------------------------------------------------
    // Capture: sample pins on the rise strobe
    // ------------------------------------------------------------------
    logic                  cmd_capture;
    logic [DATA_WIDTH-1:0] data_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_capture  <= 1'b0;
            data_capture <= '0;
        end else if (rise) begin
            cmd_capture  <= io_phy_sd_cmd;
            data_capture <= io_phy_sd_data;
        end
    end

    assign o_sd_cmd_in  = cmd_capture;
    assign o_sd_data_in = data_capture;

endmodule
`default_nettype wire

// File: tb/tb_sd_host_platform_generic.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_host_platform_generic
// Brief    : Directed self-checking bench for sd_host_platform_generic.
// Revision : 1.0
// ============================================================================
module tb_sd_host_platform_generic;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       clk_en;
    logic [7:0] clk_div;
    logic       clk_stopped;
    logic       phy_clk;
    logic       rise;
    logic       fall;
    logic       cmd_dir;
    logic       cmd_out;
    logic       cmd_in;
    logic       data_dir;
    logic [3:0] data_out;
    logic [3:0] data_in;
    wire        pin_cmd;
    wire  [3:0] pin_data;

    logic       tb_drv;
    logic       tb_cmd;
    logic [3:0] tb_data;

    int checks = 0;
    int errors = 0;

    assign pin_cmd  = tb_drv ? tb_cmd  : 1'bz;
    assign pin_data = tb_drv ? tb_data : 4'bzzzz;

    always #5 clk = ~clk;

    sd_host_platform_generic #(
        .DATA_WIDTH  (4),
        .LOCK_CYCLES (16),
        .DIV_WIDTH   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .o_locked       (locked),
        .i_clk_en       (clk_en),
        .i_clk_div      (clk_div),
        .o_clk_stopped  (clk_stopped),
        .o_phy_out_clk  (phy_clk),
        .o_sd_clk_rise  (rise),
        .o_sd_clk_fall  (fall),
        .i_sd_cmd_dir   (cmd_dir),
        .i_sd_cmd_out   (cmd_out),
        .o_sd_cmd_in    (cmd_in),
        .i_sd_data_dir  (data_dir),
        .i_sd_data_out  (data_out),
        .o_sd_data_in   (data_in),
        .io_phy_sd_cmd  (pin_cmd),
        .io_phy_sd_data (pin_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_locked"},  locked,      0);
        check({tag, "_phy"},     phy_clk,     0);
        check({tag, "_stopped"}, clk_stopped, 1);
        check({tag, "_rise"},    rise,        0);
        check({tag, "_fall"},    fall,        0);
        check({tag, "_cmdin"},   cmd_in,      0);
        check({tag, "_datain"},  data_in,     0);
    endtask

    initial begin
        rst      = 1'b1;
        clk_en   = 1'b0;
        clk_div  = 8'd3;
        cmd_dir  = 1'b0;
        cmd_out  = 1'b0;
        data_dir = 1'b0;
        data_out = 4'h0;
        tb_drv   = 1'b1;
        tb_cmd   = 1'b1;
        tb_data  = 4'h5;

        // Reset and lock
        tick(2);
        check_reset_state("rst");
        rst = 1'b0;
        tick(15);
        check("lock15_locked", locked, 0);
        check("lock15_phy", phy_clk, 0);
        check("lock15_stopped", clk_stopped, 1);
        check("lock15_pin_data", pin_data, 4'h5);
        check("lock15_pin_cmd", pin_cmd, 1);
        tick(1);
        check("lock16_locked", locked, 1);
        check("lock16_datain", data_in, 0);

        // N=3: 4 high, 4 low
        clk_en = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("n3_phy_%0d", i),  phy_clk, ((i % 8) < 4) ? 1 : 0);
            check($sformatf("n3_rise_%0d", i), rise,    ((i % 8) == 0) ? 1 : 0);
            check($sformatf("n3_fall_%0d", i), fall,    ((i % 8) == 4) ? 1 : 0);
            tick(1);
        end

        // N=0: toggle every cycle
        clk_div = 8'd0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("n0_phy_%0d", i),  phy_clk, ((i % 2) == 0) ? 1 : 0);
            check($sformatf("n0_rise_%0d", i), rise,    ((i % 2) == 0) ? 1 : 0);
            check($sformatf("n0_fall_%0d", i), fall,    ((i % 2) == 1) ? 1 : 0);
            tick(1);
        end

        // N=5 from a first-high cycle: full 12-cycle period
        clk_div = 8'd5;
        for (int j = 0; j < 12; j++) begin
            check($sformatf("n5_phy_%0d", j),  phy_clk, (j < 6) ? 1 : 0);
            check($sformatf("n5_rise_%0d", j), rise,    (j == 0) ? 1 : 0);
            check($sformatf("n5_fall_%0d", j), fall,    (j == 6) ? 1 : 0);
            tick(1);
        end
        check("n5_next_rise", rise, 1);

        // Gating with N=2
        clk_div = 8'd2;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("gate_phy_%0d", j),     phy_clk,     (j < 3) ? 1 : 0);
            check($sformatf("gate_stopped_%0d", j), clk_stopped, (j >= 6) ? 1 : 0);
            check($sformatf("gate_fall_%0d", j),    fall,        (j == 3) ? 1 : 0);
            if (j > 0) check($sformatf("gate_rise_%0d", j), rise, 0);
            if (j == 0) clk_en = 1'b0;
            if (j == 7) clk_en = 1'b1;
            tick(1);
        end
        check("regate_phy", phy_clk, 1);
        check("regate_rise", rise, 1);
        check("regate_stopped", clk_stopped, 0);

        // Drive / capture, then reset mid-transfer
        tb_drv   = 1'b0;
        data_dir = 1'b1;
        data_out = 4'hA;
        cmd_dir  = 1'b1;
        cmd_out  = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k == 4) begin
                check("launch_data", pin_data, 4'hA);
                check("launch_cmd", pin_cmd, 1);
                data_out = 4'h3;
            end
            if (k == 8) check("launch_hold", pin_data, 4'hA);
            if (k == 10) begin
                check("relaunch_data", pin_data, 4'h3);
                data_dir = 1'b0;
                cmd_dir  = 1'b0;
            end
            if (k == 13) begin
                check("cap_data_driven", data_in, 4'h3);
                check("cap_cmd_driven", cmd_in, 1);
            end
            if (k == 16) begin
                tb_drv  = 1'b1;
                tb_data = 4'h5;
                tb_cmd  = 1'b0;
            end
            if (k == 18) check("cap_hold", data_in, 4'h3);
            if (k == 19) begin
                check("cap_data_ext", data_in, 4'h5);
                check("cap_cmd_ext", cmd_in, 0);
                clk_div  = 8'd4;
                data_dir = 1'b1;
                data_out = 4'hF;
                cmd_dir  = 1'b1;
                cmd_out  = 1'b1;
            end
            if (k == 20) tb_drv = 1'b0;
            if (k == 24) check("launch_n4", pin_data, 4'hF);
            if (k == 28) check("n4_rise", rise, 1);
            if (k == 29) begin
                check("n4_high", phy_clk, 1);
                rst      = 1'b1;
                data_dir = 1'b0;
                cmd_dir  = 1'b0;
            end
            if (k == 30) begin
                check_reset_state("midrst");
                tb_data = 4'h5;
                tb_cmd  = 1'b0;
                tb_drv  = 1'b1;
            end
            if (k == 31) begin
                check("midrst_pin_data", pin_data, 4'h5);
                check("midrst_pin_cmd", pin_cmd, 0);
                rst = 1'b0;
            end
            tick(1);
        end

        // Lock restarts after the mid-run reset
        tick(14);
        check("relock15_locked", locked, 0);
        check("relock15_phy", phy_clk, 0);
        tick(1);
        check("relock16_locked", locked, 1);
        tick(1);
        check("relock_phy", phy_clk, 1);
        check("relock_rise", rise, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
